// File: rtl/vread_pkg.sv
// Shared types and helpers for the burst read unit and its address generator.
package vread_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_BEAT = 2'd2,
    F_GAP  = 2'd3
  } fetch_state_t;

  // Replace the top bank_w bits of an addr_w-bit address with the bank index.
  // When banking is off (or there are no bank bits) the address passes through.
  function automatic logic [31:0] bank_addr(
    input logic [31:0] bank,
    input logic [31:0] addr,
    input logic        en,
    input int unsigned addr_w,
    input int unsigned bank_w
  );
    logic [31:0] full_mask;
    logic [31:0] low_mask;
    logic [31:0] res;
    full_mask = (32'd1 << addr_w) - 32'd1;
    if (!en || bank_w == 0) begin
      res = addr & full_mask;
    end else begin
      low_mask = (32'd1 << (addr_w - bank_w)) - 32'd1;
      res = ((bank << (addr_w - bank_w)) | (addr & low_mask)) & full_mask;
    end
    return res;
  endfunction

  // Beats in the next burst: the remaining word count, capped at max_len.
  function automatic logic [8:0] min_len(
    input logic [31:0] remaining,
    input int unsigned max_len
  );
    logic [31:0] m;
    m = max_len;
    if (remaining < m) return remaining[8:0];
    return m[8:0];
  endfunction

endpackage

// File: rtl/vread_strided_gen.sv
// Strided address generator: after a start pulse it issues count consecutive
// memory accesses at start, start+incr, start+2*incr, ... (mod 2^ADDR_W).
module vread_strided_gen
  import vread_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] incr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_en,
  output logic [ADDR_W-1:0] addr,
  output logic              done
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic              busy;
  logic [ADDR_W:0]   left;
  logic [ADDR_W-1:0] addr_p0;
  logic [ADDR_W-1:0] incr_r;

  // Control: track how many accesses are still to be issued
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      left <= '0;
    end else if (start) begin
      busy <= (count != '0);
      left <= count;
    end else if (busy) begin
      left <= left - CNT_ONE;
      if (left == CNT_ONE) busy <= 1'b0;
    end
  end

  // Address stage: load the base on start, then step by the stride
  always_ff @(posedge clk) begin
    if (start) begin
      addr_p0 <= start_addr;
      incr_r  <= incr;
    end else if (busy) begin
      addr_p0 <= addr_p0 + incr_r;
    end
  end

  assign mem_en = busy;
  assign addr   = addr_p0;
  assign done   = ~busy;

endmodule

// File: rtl/vread_burst.sv
// Burst read unit: fetches size words from external memory in bursts of at
// most MAX_LEN beats into a rotating bank of the internal 2-port memory while
// a strided generator drains the previously filled bank to out0.
module vread_burst
  import vread_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int IO_ADDR_W = 32,
  parameter int BANK_W    = 1,
  parameter int MAX_LEN   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic                  done,
  output logic                  databus_valid,
  input  logic                  databus_ready,
  output logic [IO_ADDR_W-1:0]  databus_addr,
  output logic [7:0]            databus_len,
  input  logic [DATA_W-1:0]     databus_rdata,
  input  logic                  databus_last,
  output logic [DATA_W-1:0]     databus_wdata,
  output logic [DATA_W/8-1:0]   databus_wstrb,
  output logic                  ext_2p_write_0,
  output logic [ADDR_W-1:0]     ext_2p_addr_out_0,
  output logic [DATA_W-1:0]     ext_2p_data_out_0,
  output logic                  ext_2p_read_0,
  output logic [ADDR_W-1:0]     ext_2p_addr_in_0,
  input  logic [DATA_W-1:0]     ext_2p_data_in_0,
  output logic [DATA_W-1:0]     out0,
  output logic                  out_valid,
  input  logic [IO_ADDR_W-1:0]  ext_addr,
  input  logic [ADDR_W-1:0]     int_addr,
  input  logic [ADDR_W:0]       size,
  input  logic                  bank_en,
  input  logic [ADDR_W-1:0]     rd_start,
  input  logic [ADDR_W-1:0]     rd_incr,
  input  logic [ADDR_W:0]       rd_count
);

  localparam int            BW       = (BANK_W == 0) ? 1 : BANK_W;
  localparam int            BYTES    = DATA_W / 8;
  localparam int            RW       = ADDR_W + 1;
  localparam logic [BW-1:0] BANK_ONE = BW'(1);

  fetch_state_t          state;
  fetch_state_t          state_n;

  logic [ADDR_W:0]       remaining;
  logic [ADDR_W:0]       rem_after;
  logic [IO_ADDR_W-1:0]  addr_r;
  logic [7:0]            len_r;
  logic [8:0]            req_cnt;
  logic [ADDR_W-1:0]     wr_ptr;
  logic [BW-1:0]         bank;
  logic [BW-1:0]         rd_bank;
  logic                  bank_en_r;

  logic                  accept;
  logic                  beat;
  logic                  burst_end;

  logic                  wr_vld_p1;
  logic [ADDR_W-1:0]     wr_addr_p1;
  logic [DATA_W-1:0]     wr_data_p1;
  logic                  rd_vld_p1;

  logic                  gen_en;
  logic                  gen_done;
  logic [ADDR_W-1:0]     gen_addr;

  assign accept    = run & done;
  assign beat      = databus_valid & databus_ready;
  assign burst_end = beat & databus_last;

  // A burst that ends early on databus_last still retires its full requested
  // count, so the address and remaining count follow the request, not the bus.
  assign req_cnt   = {1'b0, len_r} + 9'd1;
  assign rem_after = remaining - RW'(req_cnt);
  assign rd_bank   = bank - BANK_ONE;

  assign done = (state == F_IDLE) & ~wr_vld_p1 & gen_done & ~rd_vld_p1;

  // Fetch FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= F_IDLE;
    else     state <= state_n;
  end

  // Fetch FSM next state and bus request
  always_comb begin
    state_n       = state;
    databus_valid = 1'b0;
    case (state)
      F_IDLE: begin
        if (accept && size != '0) state_n = F_REQ;
      end
      F_REQ: begin
        databus_valid = 1'b1;
        if (burst_end)          state_n = (rem_after != '0) ? F_GAP : F_IDLE;
        else if (databus_ready) state_n = F_BEAT;
      end
      F_BEAT: begin
        databus_valid = 1'b1;
        if (burst_end) state_n = (rem_after != '0) ? F_GAP : F_IDLE;
      end
      F_GAP: begin
        state_n = F_REQ;
      end
      default: state_n = F_IDLE;
    endcase
  end

  // Transfer bookkeeping: config latch, burst address/length, bank rotation
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      addr_r    <= '0;
      len_r     <= '0;
      wr_ptr    <= '0;
      bank      <= '0;
      bank_en_r <= 1'b0;
    end else if (accept) begin
      remaining <= size;
      addr_r    <= ext_addr;
      len_r     <= (size == '0) ? 8'd0 : 8'(min_len(32'(size), MAX_LEN) - 9'd1);
      wr_ptr    <= int_addr;
      bank_en_r <= bank_en;
      if (bank_en && BANK_W != 0) bank <= bank + BANK_ONE;
      else                        bank <= '0;
    end else begin
      if (beat) wr_ptr <= wr_ptr + 1'b1;
      if (burst_end) begin
        remaining <= rem_after;
        addr_r    <= addr_r + IO_ADDR_W'(req_cnt) * IO_ADDR_W'(BYTES);
        if (rem_after != '0)
          len_r <= 8'(min_len(32'(rem_after), MAX_LEN) - 9'd1);
      end
    end
  end

  // Stage p1 valids: write strobe one cycle after a beat, out_valid one
  // cycle after a read (memory latency)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_p1 <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      wr_vld_p1 <= beat;
      rd_vld_p1 <= gen_en;
    end
  end

  // Stage p1 write data: capture the beat and its banked address
  always_ff @(posedge clk) begin
    if (beat) begin
      wr_data_p1 <= databus_rdata;
      wr_addr_p1 <= ADDR_W'(bank_addr(32'(bank), 32'(wr_ptr), bank_en_r, ADDR_W, BANK_W));
    end
  end

  vread_strided_gen #(
    .ADDR_W (ADDR_W)
  ) u_gen (
    .clk        (clk),
    .rst        (rst),
    .start      (accept),
    .start_addr (rd_start),
    .incr       (rd_incr),
    .count      (rd_count),
    .mem_en     (gen_en),
    .addr       (gen_addr),
    .done       (gen_done)
  );

  assign databus_addr      = addr_r;
  assign databus_len       = len_r;
  assign databus_wdata     = '0;
  assign databus_wstrb     = '0;

  assign ext_2p_write_0    = wr_vld_p1;
  assign ext_2p_addr_out_0 = wr_addr_p1;
  assign ext_2p_data_out_0 = wr_data_p1;

  assign ext_2p_read_0     = gen_en;
  assign ext_2p_addr_in_0  = ADDR_W'(bank_addr(32'(rd_bank), 32'(gen_addr), bank_en_r, ADDR_W, BANK_W));

  assign out0              = ext_2p_data_in_0;
  assign out_valid         = rd_vld_p1;

endmodule
